// File: rtl/array_bank_pkg.sv
// Shared types for the array bank writer: command modes and sweep FSM states.
package array_bank_pkg;

    typedef enum logic [1:0] {
        MODE_BCAST = 2'd0,
        MODE_INDEX = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_SWEEP = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

endpackage

// File: rtl/array_bank_if.sv
// Holds the DEPTH x WIDTH configuration array; the writer drives it via modport P.
interface array_bank_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
);

    logic [WIDTH-1:0] x [DEPTH];

    modport P (output x);

endinterface

// File: rtl/array_sweep_ctrl.sv
// Sweep sequencer: walks a wrapping pointer over DEPTH elements, one per cycle,
// and pulses done once the final element has been written.
module array_sweep_ctrl
    import array_bank_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [IDX_W-1:0] start_idx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             we_o,
    output logic [IDX_W-1:0] ptr_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // cnt_q counts remaining writes; the write made with cnt_q==0 is the last one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        we_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SWEEP;
                    ptr_d   = start_idx_i;
                    cnt_d   = LAST;
                end
            end
            SWEEP: begin
                we_o  = 1'b1;
                ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == SWEEP);
    assign done_o = done_q;
    assign ptr_o  = ptr_q;

endmodule

// File: rtl/array_bank_fill.sv
// Command-driven writer for a per-lane configuration array: broadcast, indexed,
// shift and multi-cycle sweep writes behind a valid/ready handshake.
module array_bank_fill
    import array_bank_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    array_bank_if.P          j,
    input  logic             i_valid,
    output logic             o_ready,
    input  mode_e            i_mode,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_a [DEPTH],
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

    logic             accept;
    logic             idx_in_range;
    logic             sweep_start;
    logic             sweep_we;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] sweep_ptr;
    logic [WIDTH-1:0] data_q, data_d;

    assign accept       = i_valid && o_ready;
    assign idx_in_range = ({1'b0, i_idx} < DEPTH_X);
    assign sweep_start  = accept && (i_mode == MODE_SWEEP);
    assign start_idx    = idx_in_range ? i_idx : '0;
    assign o_ready      = !o_busy;
    assign data_d       = sweep_start ? i_data : data_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    array_sweep_ctrl #(
        .DEPTH (DEPTH)
    ) u_sweep (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .start_i     (sweep_start),
        .start_idx_i (start_idx),
        .busy_o      (o_busy),
        .done_o      (o_done),
        .we_o        (sweep_we),
        .ptr_o       (sweep_ptr)
    );

    // Sweep writes and accepted commands never coincide: o_ready is low while sweeping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                j.x[k] <= '0;
            end
        end else if (sweep_we) begin
            j.x[sweep_ptr] <= data_q;
        end else if (accept) begin
            unique case (i_mode)
                MODE_BCAST: begin
                    for (int k = 0; k < DEPTH; k++) begin
                        j.x[k] <= i_data;
                    end
                end
                MODE_INDEX: begin
                    if (idx_in_range) begin
                        j.x[i_idx] <= i_data;
                    end
                end
                MODE_SHIFT: begin
                    j.x[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        j.x[k] <= j.x[k-1];
                    end
                end
                MODE_SWEEP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign o_a = j.x;

endmodule

// File: tb/tb_array_bank_fill.sv
// Directed bench for array_bank_fill: an 8-deep instance for the main modes and
// a 5-deep instance for out-of-range index handling.
module tb_array_bank_fill;
    import array_bank_pkg::*;

    logic clk;
    logic rst_n;

    logic       v8, ready8, busy8, done8;
    mode_e      mode8;
    logic [2:0] idx8;
    logic [3:0] data8;
    logic [3:0] a8 [8];

    logic       v5, ready5, busy5, done5;
    mode_e      mode5;
    logic [2:0] idx5;
    logic [3:0] data5;
    logic [3:0] a5 [5];

    int tests;
    int fails;

    array_bank_if #(.WIDTH(4), .DEPTH(8)) j8 ();
    array_bank_if #(.WIDTH(4), .DEPTH(5)) j5 ();

    array_bank_fill #(.WIDTH(4), .DEPTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .j       (j8),
        .i_valid (v8),
        .o_ready (ready8),
        .i_mode  (mode8),
        .i_idx   (idx8),
        .i_data  (data8),
        .o_a     (a8),
        .o_busy  (busy8),
        .o_done  (done8)
    );

    array_bank_fill #(.WIDTH(4), .DEPTH(5)) dut5 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .j       (j5),
        .i_valid (v5),
        .o_ready (ready5),
        .i_mode  (mode5),
        .i_idx   (idx5),
        .i_data  (data5),
        .o_a     (a5),
        .o_busy  (busy5),
        .o_done  (done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one command for one cycle; returns at the negedge after the accepting edge.
    task automatic cmd8(input mode_e m, input logic [2:0] idx, input logic [3:0] d);
        @(negedge clk);
        v8 = 1'b1; mode8 = m; idx8 = idx; data8 = d;
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic cmd5(input mode_e m, input logic [2:0] idx, input logic [3:0] d);
        @(negedge clk);
        v5 = 1'b1; mode5 = m; idx5 = idx; data5 = d;
        @(negedge clk);
        v5 = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) begin
            cmd8(MODE_INDEX, 3'(k), 4'($urandom_range(1, 15)));
        end
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (a8[k] !== 4'h0) begin
                fails++;
                $display("[TB] FAIL reset_a[%0d] got %0h expected 0", k, a8[k]);
            end
        end
        tests++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL reset_flags got rdy/busy/done=%b expected 100", {ready8, busy8, done8});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_bcast_index();
        logic [3:0] exp [8];
        cmd8(MODE_BCAST, 3'd0, 4'hA);
        cmd8(MODE_INDEX, 3'd3, 4'h5);
        for (int k = 0; k < 8; k++) exp[k] = (k == 3) ? 4'h5 : 4'hA;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (a8[k] !== exp[k]) begin
                fails++;
                $display("[TB] FAIL bcast_index_a[%0d] got %0h expected %0h", k, a8[k], exp[k]);
            end
        end
        cmd8(MODE_INDEX, 3'd7, 4'h1);
        tests++;
        if (a8[7] !== 4'h1 || a8[6] !== 4'hA) begin
            fails++;
            $display("[TB] FAIL index7 got a7=%0h a6=%0h expected 1 A", a8[7], a8[6]);
        end
    endtask

    task automatic test_shift();
        logic [3:0] exp [8];
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v8 = 1'b1; mode8 = MODE_SHIFT; data8 = 4'h1;
        @(negedge clk);
        data8 = 4'h2;
        @(negedge clk);
        data8 = 4'h3;
        @(negedge clk);
        v8 = 1'b0;
        for (int k = 0; k < 8; k++) exp[k] = (k < 3) ? 4'(3 - k) : 4'h0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (a8[k] !== exp[k]) begin
                fails++;
                $display("[TB] FAIL shift3_a[%0d] got %0h expected %0h", k, a8[k], exp[k]);
            end
        end
        v8 = 1'b1; data8 = 4'h0;
        repeat (2) @(negedge clk);
        tests++;
        if (a8[2] !== 4'h3 || a8[3] !== 4'h2 || a8[4] !== 4'h1 || a8[0] !== 4'h0) begin
            fails++;
            $display("[TB] FAIL shift_mid got a0..a4=%0h %0h %0h %0h %0h expected 0 0 3 2 1",
                     a8[0], a8[1], a8[2], a8[3], a8[4]);
        end
        repeat (6) @(negedge clk);
        v8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (a8[k] !== 4'h0) begin
                fails++;
                $display("[TB] FAIL shift_flush_a[%0d] got %0h expected 0", k, a8[k]);
            end
        end
    endtask

    task automatic test_sweep_wrap();
        logic [3:0] exp [8];
        int         order;
        cmd8(MODE_BCAST, 3'd0, 4'h3);
        for (int k = 0; k < 8; k++) exp[k] = 4'h3;
        cmd8(MODE_SWEEP, 3'd6, 4'hC);
        v8 = 1'b1; mode8 = MODE_BCAST; data8 = 4'hF;
        tests++;
        if (busy8 !== 1'b1 || ready8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sweep_start_flags got busy/rdy/done=%b%b%b expected 100", busy8, ready8, done8);
        end
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            order = (6 + w) % 8;
            exp[order] = 4'hC;
            for (int k = 0; k < 8; k++) begin
                tests++;
                if (a8[k] !== exp[k]) begin
                    fails++;
                    $display("[TB] FAIL sweep_w%0d_a[%0d] got %0h expected %0h", w, k, a8[k], exp[k]);
                end
            end
            tests++;
            if (w < 7) begin
                if (busy8 !== 1'b1 || ready8 !== 1'b0 || done8 !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL sweep_w%0d_flags got busy/rdy/done=%b%b%b expected 100", w, busy8, ready8, done8);
                end
            end else begin
                if (busy8 !== 1'b0 || ready8 !== 1'b1 || done8 !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL sweep_done_flags got busy/rdy/done=%b%b%b expected 011", busy8, ready8, done8);
                end
            end
            if (w == 6) v8 = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (done8 !== 1'b0 || a8[5] !== 4'hC) begin
            fails++;
            $display("[TB] FAIL sweep_after got done=%b a5=%0h expected 0 C", done8, a8[5]);
        end
    endtask

    task automatic test_boundary_depth5();
        int done_seen;
        cmd5(MODE_BCAST, 3'd0, 4'h2);
        cmd5(MODE_INDEX, 3'd6, 4'h9);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (a5[k] !== 4'h2) begin
                fails++;
                $display("[TB] FAIL d5_index_oob_a[%0d] got %0h expected 2", k, a5[k]);
            end
        end
        cmd5(MODE_SWEEP, 3'd7, 4'h4);
        done_seen = 0;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            if (done5 === 1'b1) done_seen++;
            tests++;
            if (a5[w] !== 4'h4 || (w < 4 && a5[w+1] !== 4'h2)) begin
                fails++;
                $display("[TB] FAIL d5_sweep_w%0d got a[%0d]=%0h expected 4 with next still 2", w, w, a5[w]);
            end
            tests++;
            if (done5 !== (w == 4) || busy5 !== (w < 4)) begin
                fails++;
                $display("[TB] FAIL d5_sweep_w%0d_flags got done/busy=%b%b expected %b%b",
                         w, done5, busy5, (w == 4), (w < 4));
            end
        end
        tests++;
        if (done_seen !== 1) begin
            fails++;
            $display("[TB] FAIL d5_done_count got %0d expected 1", done_seen);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        cmd8(MODE_BCAST, 3'd0, 4'h1);
        cmd8(MODE_SWEEP, 3'd2, 4'h7);
        repeat (3) @(negedge clk);
        tests++;
        if (a8[4] !== 4'h7 || a8[5] !== 4'h1) begin
            fails++;
            $display("[TB] FAIL mid_sweep_partial got a4=%0h a5=%0h expected 7 1", a8[4], a8[5]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (a8[k] !== 4'h0) begin
                fails++;
                $display("[TB] FAIL mid_reset_a[%0d] got %0h expected 0", k, a8[k]);
            end
        end
        tests++;
        if ({ready8, busy8, done8} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL mid_reset_flags got rdy/busy/done=%b expected 100", {ready8, busy8, done8});
        end
        rst_n = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 !== 1'b0 || a8[7] !== 4'h0) done_seen++;
        end
        tests++;
        if (done_seen !== 0) begin
            fails++;
            $display("[TB] FAIL mid_reset_aftermath got %0d bad cycles expected 0", done_seen);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        v8 = 1'b0; mode8 = MODE_BCAST; idx8 = '0; data8 = '0;
        v5 = 1'b0; mode5 = MODE_BCAST; idx5 = '0; data5 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_bcast_index();
        test_shift();
        test_sweep_wrap();
        test_boundary_depth5();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
